// File: rtl/operand_entry.sv
// Operand capture front-end: two-flop button sync, per-button debounce, and an
// A -> B -> SHOW sequencer. Define OPERAND_ECHO_EN to add the disp_val preview port.
module operand_entry #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw,
    input  logic       btn_next,
    input  logic       btn_clr,
    output logic [3:0] a,
    output logic [3:0] b,
    output logic       operands_valid,
    output logic [1:0] state_led
`ifdef OPERAND_ECHO_EN
    ,
    output logic [3:0] disp_val
`endif
);

    localparam int unsigned NBTN = 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_A    = 2'b00,
        S_B    = 2'b01,
        S_SHOW = 2'b10
    } state_t;

    logic [NBTN-1:0]  raw;
    logic [NBTN-1:0]  sync1;
    logic [NBTN-1:0]  sync2;
    logic [NBTN-1:0]  deb;
    logic [NBTN-1:0]  deb_prev;
    logic [CNT_W-1:0] cnt [NBTN];
    logic [NBTN-1:0]  press_c;
    logic             next_c;
    logic             clr_c;
    state_t           state;

    assign raw = {btn_clr, btn_next};

    // Sync and debounce; bit 0 is next, bit 1 is clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            deb      <= '0;
            deb_prev <= '0;
            for (int i = 0; i < int'(NBTN); i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            deb_prev <= deb;
            for (int i = 0; i < int'(NBTN); i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    deb[i] <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Rising edge of the debounced level only; releases are ignored.
    assign press_c = deb & ~deb_prev;
    assign next_c  = press_c[0];
    assign clr_c   = press_c[1];

    // Sequencer; clear beats next when both fire together.
    always_ff @(posedge clk) begin
        if (rst || clr_c) begin
            state          <= S_A;
            a              <= '0;
            b              <= '0;
            operands_valid <= 1'b0;
        end else begin
            case (state)
                S_A: begin
                    if (next_c) begin
                        a     <= sw;
                        state <= S_B;
                    end
                end
                S_B: begin
                    if (next_c) begin
                        b              <= sw;
                        operands_valid <= 1'b1;
                        state          <= S_SHOW;
                    end
                end
                S_SHOW: begin
                    if (next_c) begin
                        a              <= sw;
                        operands_valid <= 1'b0;
                        state          <= S_B;
                    end
                end
                default: begin
                    state          <= S_A;
                    a              <= '0;
                    b              <= '0;
                    operands_valid <= 1'b0;
                end
            endcase
        end
    end

    assign state_led = state;

`ifdef OPERAND_ECHO_EN
    // Live switch preview while entering, sum once both operands are shown.
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_val <= '0;
        end else if (state == S_SHOW) begin
            disp_val <= 4'(a + b);
        end else begin
            disp_val <= sw;
        end
    end
`endif

endmodule

// File: tb/tb_operand_entry.sv
// Scoreboard bench for operand_entry with a short debounce window.
module tb_operand_entry;

    localparam int unsigned DEB = 4;
    localparam int unsigned CW  = 3;
    localparam int          LAT = int'(DEB) + 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sw;
    logic       btn_next;
    logic       btn_clr;
    logic [3:0] a;
    logic [3:0] b;
    logic       operands_valid;
    logic [1:0] state_led;
`ifdef OPERAND_ECHO_EN
    logic [3:0] disp_val;
`endif

    operand_entry #(.DEBOUNCE_CYCLES(DEB), .CNT_W(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .sw             (sw),
        .btn_next       (btn_next),
        .btn_clr        (btn_clr),
        .a              (a),
        .b              (b),
        .operands_valid (operands_valid),
        .state_led      (state_led)
`ifdef OPERAND_ECHO_EN
        ,
        .disp_val       (disp_val)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic       v;
        logic [1:0] st;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    logic [3:0] m_a;
    logic [3:0] m_b;
    logic       m_v;
    logic [1:0] m_st;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_a = 4'h0; m_b = 4'h0; m_v = 1'b0; m_st = 2'b00;
    endtask

    task automatic model_next(input logic [3:0] s);
        case (m_st)
            2'b00: begin m_a = s; m_st = 2'b01; end
            2'b01: begin m_b = s; m_v = 1'b1; m_st = 2'b10; end
            2'b10: begin m_a = s; m_v = 1'b0; m_st = 2'b01; end
            default: model_clear();
        endcase
    endtask

    task automatic push_exp();
        exp_q.push_back('{a: m_a, b: m_b, v: m_v, st: m_st});
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            check({tag, "_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_a"},     32'(a),              32'(e.a));
            check({tag, "_b"},     32'(b),              32'(e.b));
            check({tag, "_valid"}, 32'(operands_valid), 32'(e.v));
            check({tag, "_state"}, 32'(state_led),      32'(e.st));
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    // Press next and/or clear with sw held, measure edges until outputs move.
    task automatic press(input string tag, input logic nxt, input logic clr,
                         input logic [3:0] s, input int hold);
        logic [10:0] prev;
        int          lat;
        bit          changed;
        @(negedge clk);
        sw = s; btn_next = nxt; btn_clr = clr;
        if (clr) model_clear();
        else if (nxt) model_next(s);
        push_exp();
        prev = {a, b, operands_valid, state_led};
        changed = 0;
        lat = -1;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            if (!changed && ({a, b, operands_valid, state_led} != prev)) begin
                changed = 1;
                lat = k + 1;
            end
        end
        @(negedge clk);
        btn_next = 1'b0; btn_clr = 1'b0;
        check({tag, "_lat"}, 32'(lat), 32'(LAT));
        idle(int'(DEB) + 8);
        check_out(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; btn_next = 1'b0; btn_clr = 1'b0;
        idle(2);
        rst = 1'b0;
        model_clear();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst = 1'b1; sw = 4'h0; btn_next = 1'b0; btn_clr = 1'b0;
        do_reset();
        push_exp();
        #1;
        check_out("reset");

        press("cap_a", 1'b1, 1'b0, 4'h3, 10);
        press("cap_b", 1'b1, 1'b0, 4'h5, 10);
        press("recap", 1'b1, 1'b0, 4'hF, 10);
        press("clr",   1'b0, 1'b1, 4'h0, 10);
        press("cap_9", 1'b1, 1'b0, 4'h9, 10);
        press("clr_pri", 1'b1, 1'b1, 4'h7, 10);

        // Single-cycle glitches must never reach the sequencer.
        sw = 4'hA;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); btn_next = 1'b1;
            @(negedge clk); btn_next = 1'b0;
        end
        idle(20);
        push_exp();
        check_out("bounce");

        press("held", 1'b1, 1'b0, 4'h2, 50);

        // Reset lands two cycles into a debounce; nothing may leak out afterwards.
        @(negedge clk);
        sw = 4'h4; btn_next = 1'b1;
        for (int k = 0; k < 4; k++) @(posedge clk);
        @(negedge clk);
        rst = 1'b1; btn_next = 1'b0;
        idle(2);
        rst = 1'b0;
        model_clear();
        push_exp();
        #1;
        check_out("mid_rst_now");
        idle(20);
        push_exp();
        check_out("mid_rst_late");

`ifdef OPERAND_ECHO_EN
        begin
            logic [3:0] ea;
            logic [3:0] eb;
            ea = 4'h7; eb = 4'hC;
            press("echo_a", 1'b1, 1'b0, ea, 10);
            press("echo_b", 1'b1, 1'b0, eb, 10);
            check("echo_sum", 32'(disp_val), 32'(4'(ea + eb)));
            press("echo_rc", 1'b1, 1'b0, 4'h1, 10);
            @(negedge clk);
            sw = 4'h6;
            @(posedge clk);
            #1;
            check("echo_live", 32'(disp_val), 32'h6);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/operand_entry.md
Name: operand_entry

Overview:
- Front-end operand source for the 4-bit adder/seven-segment datapath.
- Captures two 4-bit operands from slide switches under push-button control.
- Buttons are synchronised and debounced; a 3-state FSM sequences operand A, then operand B, then result display.
- Drives a, b and operands_valid into the adder and exposes FSM state on LEDs.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles needed before a button level is accepted. 10 ms at 100 MHz. Minimum 2.
- CNT_W, 20, width of each debounce counter. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock; sole clock domain.
- rst  input  1  synchronous, active-high reset.
- sw  input  4  raw operand switches; sampled directly, not debounced.
- btn_next  input  1  raw, asynchronous "capture/advance" button.
- btn_clr  input  1  raw, asynchronous "clear" button.
- a  output  4  captured operand A.
- b  output  4  captured operand B.
- operands_valid  output  1  high while both operands are captured and stable.
- state_led  output  2  FSM state code: 00 = S_A, 01 = S_B, 10 = S_SHOW.

Behaviour:
- Clocking and reset: single clock domain; all registers update on the rising edge of clk.
- Reset (rst=1 at an edge):
  - a=0, b=0, operands_valid=0, state=S_A, state_led=00.
  - Synchroniser flops, debounced levels and counters all cleared.
  - Reset mid-debounce or mid-sequence discards everything; no pulse may be emitted in the cycle after reset.
- Synchroniser: each button passes through 2 flops.
- Debouncer, per button:
  - Counter resets to 0 whenever the synced level equals the debounced level.
  - Otherwise the counter increments each cycle.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced level takes the synced level and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES cycles are ignored.
- Press pulse: one-cycle pulse on a 0->1 transition of the debounced level. Latency from raw edge to pulse is DEBOUNCE_CYCLES+2 cycles. Releases generate no pulse.
- FSM (updates on the edge after a pulse):
  - S_A, next pulse: a<=sw; go to S_B.
  - S_B, next pulse: b<=sw; operands_valid<=1; go to S_SHOW.
  - S_SHOW, next pulse: a<=sw; operands_valid<=0; go to S_B. b keeps its old value until recaptured.
  - Any state, clr pulse: a<=0, b<=0, operands_valid<=0; go to S_A.
  - clr and next pulses in the same cycle: clr wins; next is dropped.
  - Held button: exactly one pulse per press, no auto-repeat.
  - Unused state code 11: recover to S_A with a, b and operands_valid cleared, same as clr.
- Output timing: outputs are registered. operands_valid rises in the same cycle b becomes valid.
- Width: sw is captured as-is into 4-bit registers; no arithmetic in the core path.

Optional Feature:
- Macro: OPERAND_ECHO_EN.
- Defined:
  - Adds output disp_val [3:0], registered, reset 0.
  - In S_A and S_B, disp_val follows sw with one cycle of latency, for live preview on the display.
  - In S_SHOW, disp_val = (a+b) mod 16.
- Not defined: the disp_val port and its logic are absent; all other behaviour is identical.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset then sequence: rst high 2 cycles; sw=3, press next 10 cycles; sw=5, press next 10 cycles.
  - Expect a=3, b=5, operands_valid=1, state_led=10.
  - Each pulse arrives exactly 6 cycles after its raw edge.
- Bounce rejection: toggle btn_next 1-cycle high/low 5 times -> no pulse; state stays S_A; a=0.
- Clear priority: in S_B with a=9, assert btn_clr and btn_next on the same cycle for 10 cycles.
  - Expect state S_A, a=0, b=0, operands_valid=0.
  - No capture into b.
- Recapture from S_SHOW: from a=3, b=5 valid, set sw=F and press next.
  - Expect a=F, b=5, operands_valid=0, state_led=01.
- Held button plus mid-operation reset:
  - Hold btn_next for 50 cycles -> exactly one pulse.
  - Assert rst while a debounce counter is at 2 -> all outputs 0 and no pulse after reset releases with the button low.
- OPERAND_ECHO_EN: with a=7, b=C in S_SHOW -> disp_val=3; back in S_B with sw=6 -> disp_val=6 one cycle later.
